// File: rtl/idu_issue_ctrl.sv
// idu_issue_ctrl: single-slot issue stage between the IDU and the EXU.
// Holds one decoded instruction in a registered slot with valid/ready on both sides.
// A per-register scoreboard blocks issue while any source or destination
// register of the incoming instruction has an outstanding write, including
// a write still waiting in the slot itself. Hazard stall cycles are counted.
// Optional feature macro: IDU_WB_BYPASS_EN. When it is defined, a register
// whose busy bit is being cleared by this cycle's writeback no longer blocks
// issue, so the dependent instruction is accepted in the writeback cycle.
module idu_issue_ctrl #(
  parameter int REG_ADDRW = 5,
  parameter int NREG      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [REG_ADDRW-1:0] i_rs1id,
  input  logic [REG_ADDRW-1:0] i_rs2id,
  input  logic [REG_ADDRW-1:0] i_rdid,
  input  logic                 i_rdwen,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [REG_ADDRW-1:0] o_rs1id,
  output logic [REG_ADDRW-1:0] o_rs2id,
  output logic [REG_ADDRW-1:0] o_rdid,
  output logic                 o_rdwen,
  input  logic                 i_flush,
  input  logic                 i_wb_valid,
  input  logic [REG_ADDRW-1:0] i_wb_rdid,
  output logic [NREG-1:0]      o_busy,
  output logic [31:0]          o_stall_cnt
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [REG_ADDRW-1:0] rs1_r;
  logic [REG_ADDRW-1:0] rs2_r;
  logic [REG_ADDRW-1:0] rd_r;
  logic                 rdwen_r;
  logic [NREG-1:0]      busy_r;
  logic [NREG-1:0]      busy_nxt_s;
  logic [NREG-1:0]      wb_clr_s;
  logic [NREG-1:0]      busy_set_s;
  logic [NREG-1:0]      hit_vec_s;
  logic [31:0]          stall_cnt_r;
  logic                 fire_in_s;
  logic                 fire_out_s;
  logic                 dest_wr_s;
  logic                 slot_wr_s;
  logic                 slot_full_s;
  logic                 hazard_s;
  logic                 pre_ready_s;
  logic                 stall_inc_s;
  logic                 load_slot_s;

  assign slot_full_s = (state_r == ST_FULL);
  assign dest_wr_s   = i_rdwen & (i_rdid != {REG_ADDRW{1'b0}});
  assign slot_wr_s   = rdwen_r & (rd_r != {REG_ADDRW{1'b0}});

  // Decode the retiring write and the issuing write into one-hot register vectors.
  always_comb begin
    wb_clr_s   = {NREG{1'b0}};
    busy_set_s = {NREG{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      wb_clr_s[i]   = i_wb_valid & (i_wb_rdid == REG_ADDRW'(i));
      busy_set_s[i] = fire_out_s & slot_wr_s & (rd_r == REG_ADDRW'(i));
    end
  end

  // Per-register hit: pending write in the scoreboard or in the not-yet-issued slot; x0 never hits.
  always_comb begin
    hit_vec_s = {NREG{1'b0}};
    for (int i = 1; i < NREG; i++) begin
`ifdef IDU_WB_BYPASS_EN
      hit_vec_s[i] = (busy_r[i] & ~wb_clr_s[i]) |
                     (slot_full_s & slot_wr_s & (rd_r == REG_ADDRW'(i)));
`else
      hit_vec_s[i] = busy_r[i] |
                     (slot_full_s & slot_wr_s & (rd_r == REG_ADDRW'(i)));
`endif
    end
  end

  // Hazard on either source, or on the destination (WAW), then the input-side ready.
  always_comb begin
    hazard_s    = i_pre_valid & (hit_vec_s[i_rs1id] | hit_vec_s[i_rs2id] |
                                 (dest_wr_s & hit_vec_s[i_rdid]));
    pre_ready_s = ~i_flush & ~hazard_s & (~slot_full_s | i_post_ready);
    fire_in_s   = i_pre_valid & pre_ready_s;
    fire_out_s  = slot_full_s & i_post_ready;
    stall_inc_s = i_pre_valid & hazard_s & ~i_flush;
  end

  // Slot state machine next-state; flush overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    load_slot_s = 1'b0;
    if (i_flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (fire_in_s) begin
            state_nxt_s = ST_FULL;
            load_slot_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire_in_s) begin
            state_nxt_s = ST_FULL;
            load_slot_s = 1'b1;
          end else if (fire_out_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Scoreboard next value: clear on writeback, set on issue (set wins), x0 pinned to zero.
  always_comb begin
    busy_nxt_s    = (busy_r & ~wb_clr_s) | busy_set_s;
    busy_nxt_s[0] = 1'b0;
  end

  // Slot state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Slot payload registers; loaded on every accepted instruction.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rs1_r   <= {REG_ADDRW{1'b0}};
      rs2_r   <= {REG_ADDRW{1'b0}};
      rd_r    <= {REG_ADDRW{1'b0}};
      rdwen_r <= 1'b0;
    end else if (load_slot_s) begin
      rs1_r   <= i_rs1id;
      rs2_r   <= i_rs2id;
      rd_r    <= i_rdid;
      rdwen_r <= i_rdwen;
    end
  end

  // Scoreboard register; flush leaves it alone since issued writes still retire.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Saturating hazard-stall counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_inc_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign o_pre_ready  = pre_ready_s;
  assign o_post_valid = slot_full_s;
  assign o_rs1id      = rs1_r;
  assign o_rs2id      = rs2_r;
  assign o_rdid       = rd_r;
  assign o_rdwen      = rdwen_r;
  assign o_busy       = busy_r;
  assign o_stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Directed testbench for idu_issue_ctrl; expected values are hand-computed.
// Expectations follow IDU_WB_BYPASS_EN when the bench is built with that macro.
module tb_idu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pre_valid;
  logic        pre_ready;
  logic [4:0]  rs1id;
  logic [4:0]  rs2id;
  logic [4:0]  rdid;
  logic        rdwen;
  logic        post_valid;
  logic        post_ready;
  logic [4:0]  o_rs1id;
  logic [4:0]  o_rs2id;
  logic [4:0]  o_rdid;
  logic        o_rdwen;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rdid;
  logic [31:0] busy;
  logic [31:0] stall_cnt;

  int n_checks;
  int n_errors;

`ifdef IDU_WB_BYPASS_EN
  localparam logic [31:0] STALL_AFTER_RAW = 32'd2;
  localparam logic [31:0] READY_IN_WB     = 32'd1;
`else
  localparam logic [31:0] STALL_AFTER_RAW = 32'd3;
  localparam logic [31:0] READY_IN_WB     = 32'd0;
`endif

  idu_issue_ctrl #(.REG_ADDRW(5), .NREG(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pre_valid  (pre_valid),
    .o_pre_ready  (pre_ready),
    .i_rs1id      (rs1id),
    .i_rs2id      (rs2id),
    .i_rdid       (rdid),
    .i_rdwen      (rdwen),
    .o_post_valid (post_valid),
    .i_post_ready (post_ready),
    .o_rs1id      (o_rs1id),
    .o_rs2id      (o_rs2id),
    .o_rdid       (o_rdid),
    .o_rdwen      (o_rdwen),
    .i_flush      (flush),
    .i_wb_valid   (wb_valid),
    .i_wb_rdid    (wb_rdid),
    .o_busy       (busy),
    .o_stall_cnt  (stall_cnt)
  );

  // Free-running core clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock and return just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction on the IDU side and let combinational outputs settle.
  task automatic drive(input logic pv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic we);
    pre_valid = pv;
    rs1id     = r1;
    rs2id     = r2;
    rdid      = rd;
    rdwen     = we;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    pre_valid  = 1'b0;
    rs1id      = 5'd0;
    rs2id      = 5'd0;
    rdid       = 5'd0;
    rdwen      = 1'b0;
    post_ready = 1'b0;
    flush      = 1'b0;
    wb_valid   = 1'b0;
    wb_rdid    = 5'd0;

    // Reset state
    step();
    step();
    check_val("rst_post_valid", {31'd0, post_valid}, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    check_val("rst_stall", stall_cnt, 32'd0);
    check_val("rst_rdid", {27'd0, o_rdid}, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back independent issue: addi x1, addi x2
    post_ready = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1);
    check_val("b2b_ready0", {31'd0, pre_ready}, 32'd1);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1);
    check_val("b2b_ready1", {31'd0, pre_ready}, 32'd1);
    check_val("b2b_valid0", {31'd0, post_valid}, 32'd1);
    check_val("b2b_slot_rd1", {27'd0, o_rdid}, 32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_val("b2b_valid1", {31'd0, post_valid}, 32'd1);
    check_val("b2b_slot_rd2", {27'd0, o_rdid}, 32'd2);
    check_val("b2b_busy_mid", busy, 32'h2);
    step();
    check_val("b2b_valid_end", {31'd0, post_valid}, 32'd0);
    check_val("b2b_busy", busy, 32'h6);
    wb_valid = 1'b1;
    wb_rdid  = 5'd1;
    step();
    wb_rdid  = 5'd2;
    step();
    wb_valid = 1'b0;
    #1;
    check_val("b2b_busy_clr", busy, 32'h0);

    // RAW stall on x5
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    check_val("raw_prod_ready", {31'd0, pre_ready}, 32'd1);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
    check_val("raw_slot_stall", {31'd0, pre_ready}, 32'd0);
    check_val("raw_stall_c0", stall_cnt, 32'd0);
    step();
    check_val("raw_busy_stall", {31'd0, pre_ready}, 32'd0);
    check_val("raw_busy5", busy, 32'h20);
    check_val("raw_stall_c1", stall_cnt, 32'd1);
    step();
    wb_valid = 1'b1;
    wb_rdid  = 5'd5;
    #1;
    check_val("raw_wb_cycle_ready", {31'd0, pre_ready}, READY_IN_WB);
    check_val("raw_stall_c2", stall_cnt, 32'd2);
    step();
    wb_valid = 1'b0;
`ifdef IDU_WB_BYPASS_EN
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_val("raw_busy5_clr", {31'd0, busy[5]}, 32'd0);
    check_val("raw_accepted", {31'd0, post_valid}, 32'd1);
    check_val("raw_stall_final", stall_cnt, STALL_AFTER_RAW);
`else
    #1;
    check_val("raw_late_ready", {31'd0, pre_ready}, 32'd1);
    check_val("raw_busy5_clr", {31'd0, busy[5]}, 32'd0);
    check_val("raw_stall_final", stall_cnt, STALL_AFTER_RAW);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_val("raw_accepted", {31'd0, post_valid}, 32'd1);
`endif
    check_val("raw_slot_rd6", {27'd0, o_rdid}, 32'd6);
    step();
    check_val("raw_busy6", busy, 32'h40);
    wb_valid = 1'b1;
    wb_rdid  = 5'd6;
    step();
    wb_valid = 1'b0;
    #1;
    check_val("raw_busy_clr", busy, 32'h0);

    // Slot dependency under backpressure
    post_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    check_val("slot_load_ready", {31'd0, pre_ready}, 32'd1);
    step();
    drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
    check_val("slot_bp_ready", {31'd0, pre_ready}, 32'd0);
    post_ready = 1'b1;
    #1;
    check_val("slot_dep_ready", {31'd0, pre_ready}, 32'd0);
    check_val("slot_valid", {31'd0, post_valid}, 32'd1);
    step();
    check_val("slot_issued", {31'd0, post_valid}, 32'd0);
    check_val("slot_busy7", busy, 32'h80);
    check_val("slot_busy_stall", {31'd0, pre_ready}, 32'd0);
    step();
    check_val("slot_stall_cnt", stall_cnt, STALL_AFTER_RAW + 32'd2);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_valid = 1'b1;
    wb_rdid  = 5'd7;
    step();
    wb_valid = 1'b0;

    // Flush with the slot full and the EXU stalled
    post_ready = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    step();
    check_val("flush_full", {31'd0, post_valid}, 32'd1);
    flush = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    check_val("flush_ready_full", {31'd0, pre_ready}, 32'd0);
    step();
    check_val("flush_valid", {31'd0, post_valid}, 32'd0);
    check_val("flush_busy3", {31'd0, busy[3]}, 32'd0);
    check_val("flush_ready_empty", {31'd0, pre_ready}, 32'd0);
    flush = 1'b0;
    #1;
    check_val("flush_ready_after", {31'd0, pre_ready}, 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    check_val("flush_stays_empty", {31'd0, post_valid}, 32'd0);

    // Set/clear collision on x4, then an all-x0 instruction
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    post_ready = 1'b1;
    wb_valid   = 1'b1;
    wb_rdid    = 5'd4;
    step();
    wb_valid = 1'b0;
    #1;
    check_val("coll_busy4", busy, 32'h10);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    check_val("x0_ready", {31'd0, pre_ready}, 32'd1);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    check_val("x0_ready_full", {31'd0, pre_ready}, 32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    check_val("x0_busy", busy, 32'h10);
    check_val("x0_stall_cnt", stall_cnt, STALL_AFTER_RAW + 32'd2);

    // Synchronous reset with the slot full and x4/x5 pending
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    step();
    drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
    check_val("mid_ready", {31'd0, pre_ready}, 32'd1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    post_ready = 1'b0;
    #1;
    check_val("mid_busy", busy, 32'h30);
    check_val("mid_full", {31'd0, post_valid}, 32'd1);
    check_val("mid_slot", {22'd0, o_rs1id, o_rs2id, o_rdid}, {22'd0, 5'd1, 5'd2, 5'd8});
    rst_n = 1'b0;
    step();
    check_val("mrst_valid", {31'd0, post_valid}, 32'd0);
    check_val("mrst_busy", busy, 32'h0);
    check_val("mrst_stall", stall_cnt, 32'd0);
    check_val("mrst_slot", {26'd0, o_rdwen, o_rdid}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
